// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU-wide constants and helpers.
//   Branch predictor defaults:
//     BP_ENTRIES_DEFAULT   - default branch target buffer depth
//     BP_CTR_BITS_DEFAULT  - default direction counter width
//   Helper:
//     bp_weak_taken(bits)  - counter value for a freshly allocated entry
//                            (weakly taken = 2^(bits-1))
// ----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int BP_ENTRIES_DEFAULT  = 16;
  localparam int BP_CTR_BITS_DEFAULT = 2;
  localparam int BP_CTR_BITS_MAX     = 4;

  // Returned in the widest supported counter width; callers truncate to
  // their own CTR_BITS.
  function automatic logic [BP_CTR_BITS_MAX-1:0] bp_weak_taken(input int bits);
    return BP_CTR_BITS_MAX'(1 << (bits - 1));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Next-value logic for a saturating up/down counter. Purely combinational.
//   Parameters:
//     WIDTH       - counter width in bits
//   Ports:
//     value       in   WIDTH  current counter value
//     inc         in   1      1 = count up, 0 = count down
//     value_next  out  WIDTH  next value, held at all-ones / zero at the ends
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] value,
  input  logic             inc,
  output logic [WIDTH-1:0] value_next
);

  always_comb begin
    value_next = value;
    if (inc) begin
      if (value != {WIDTH{1'b1}}) begin
        value_next = value + WIDTH'(1);
      end
    end else begin
      if (value != {WIDTH{1'b0}}) begin
        value_next = value - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with a saturating direction counter
//   per entry. Fetch looks up the current PC combinationally; execute writes
//   back each resolved branch/jump, and a misprediction flag is raised for
//   the hazard unit.
//
//   Parameters:
//     ENTRIES   - table depth (power of two, >= 2)
//     CTR_BITS  - direction counter width (1..4)
//     ADDR_W    - PC width
//
//   Ports:
//     CLK               in   1       clock, rising edge
//     nRST              in   1       synchronous active-low reset
//     lookup_pc         in   ADDR_W  PC presented to imem
//     pred_taken        out  1       hit and counter MSB set
//     pred_target       out  ADDR_W  stored target on hit, else 0
//     upd_valid         in   1       resolved control-flow instruction
//     upd_pc            in   ADDR_W  PC of the resolved instruction
//     upd_taken         in   1       actual direction
//     upd_target        in   ADDR_W  actual target
//     upd_pred_taken    in   1       prediction carried with the instruction
//     upd_pred_target   in   ADDR_W  predicted target carried with it
//     invalidate        in   1       clear all valid bits at the next edge
//     mispredict        out  1       combinational misprediction flag
//     stat_branches     out  32      resolved branch count
//     stat_mispredicts  out  32      misprediction count
//
//   Configuration macro: BRANCH_PREDICTOR_STATS_EN
//     defined   - the two stat counters are implemented (wrap mod 2^32,
//                 cleared by reset only)
//     undefined - stat outputs are tied to 0 and no counter flops exist
// ----------------------------------------------------------------------------
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = BP_ENTRIES_DEFAULT,
  parameter int CTR_BITS = BP_CTR_BITS_DEFAULT,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              invalidate,
  output logic              mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(bp_weak_taken(CTR_BITS));

  generate
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("branch_predictor: ENTRIES must be a power of two >= 2");
    end
    if (CTR_BITS < 1 || CTR_BITS > BP_CTR_BITS_MAX) begin : g_bad_ctr
      $error("branch_predictor: CTR_BITS must be in 1..4");
    end
  endgenerate

  // Widths depend on the parameters, so the entry layout lives here.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t table_reg [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup path (combinational, sees the contents before any same-cycle
  // update because the table only changes at the edge)
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = table_reg[lk_idx].valid && (table_reg[lk_idx].tag == lk_tag);

  assign pred_taken  = lk_hit & table_reg[lk_idx].ctr[CTR_BITS-1];
  assign pred_target = lk_hit ? table_reg[lk_idx].target : '0;

  // --------------------------------------------------------------------------
  // Misprediction: wrong direction, or taken with the wrong target
  // --------------------------------------------------------------------------
  assign mispredict = upd_valid &
                      ((upd_taken != upd_pred_taken) |
                       (upd_taken & (upd_target != upd_pred_target)));

  // --------------------------------------------------------------------------
  // Update path
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [CTR_BITS-1:0] ctr_next;
  logic [ENTRIES-1:0]  sel_upd;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit = table_reg[upd_idx].valid && (table_reg[upd_idx].tag == upd_tag);
  assign upd_ctr = table_reg[upd_idx].ctr;

  sat_counter #(
    .WIDTH (CTR_BITS)
  ) u_sat_counter (
    .value      (upd_ctr),
    .inc        (upd_taken),
    .value_next (ctr_next)
  );

  // Per-entry write select; invalidate suppresses every table write except
  // the valid-bit clear.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign sel_upd[gi] = upd_valid & ~invalidate & (upd_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (invalidate) begin
          table_reg[i].valid <= 1'b0;
        end else if (sel_upd[i]) begin
          if (upd_hit) begin
            table_reg[i].ctr <= ctr_next;
            if (upd_taken) begin
              table_reg[i].target <= upd_target;
            end
          end else if (upd_taken) begin
            // Allocate on a taken miss, evicting whatever aliased here.
            table_reg[i] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CTR_WEAK};
          end
        end
      end
    end
  end

  // Byte-offset bits never select an entry.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (upd_valid) begin
        stat_branches_reg <= stat_branches_reg + 32'd1;
      end
      if (mispredict) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//   Self-checking bench for branch_predictor (ENTRIES=16, CTR_BITS=2).
//   Table-driven rows with a scoreboard queue, plus hand-written sequences
//   for reset during an update and the performance counters.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        invalidate;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 CLK = ~CLK;

  branch_predictor #(
    .ENTRIES  (16),
    .CTR_BITS (2),
    .ADDR_W   (32)
  ) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .invalidate       (invalidate),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        inv;
    logic        exp_pt;
    logic [31:0] exp_tgt;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          row;
    logic        exp_pt;
    logic [31:0] exp_tgt;
    logic        exp_mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   row_no = 0;
  int   model_br  = 0;
  int   model_mis = 0;

  function automatic vec_t mk(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt, input logic upt,
                              input logic [31:0] uptgt, input logic inv, input logic exp_pt,
                              input logic [31:0] exp_tgt, input logic exp_mis);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.inv = inv;
    v.exp_pt = exp_pt; v.exp_tgt = exp_tgt; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Lookup-only row
  function automatic vec_t lk(input logic [31:0] lpc, input logic exp_pt, input logic [31:0] exp_tgt);
    return mk(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, exp_pt, exp_tgt, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one row after the rising edge, check at the falling edge; the
  // row's update then takes effect at the following rising edge.
  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge CLK);
    #1;
    lookup_pc       = v.lpc;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
    invalidate      = v.inv;
    row_no++;
    if (v.uv) model_br++;
    if (v.exp_mis) model_mis++;
    sb.push_back('{row: row_no, exp_pt: v.exp_pt, exp_tgt: v.exp_tgt, exp_mis: v.exp_mis});
    @(negedge CLK);
    e = sb.pop_front();
    check($sformatf("row%0d pred_taken", e.row), {31'b0, pred_taken}, {31'b0, e.exp_pt});
    check($sformatf("row%0d pred_target", e.row), pred_target, e.exp_tgt);
    check($sformatf("row%0d mispredict", e.row), {31'b0, mispredict}, {31'b0, e.exp_mis});
    $display("row %0d lookup=%h upd=%b/%h inv=%b -> pt=%b tgt=%h mis=%b",
             e.row, v.lpc, v.uv, v.upc, v.inv, pred_taken, pred_target, mispredict);
  endtask

  task automatic check_stats(input string tag, input int br, input int mis);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check({tag, " stat_branches"}, stat_branches, 32'(br));
    check({tag, " stat_mispredicts"}, stat_mispredicts, 32'(mis));
`else
    check({tag, " stat_branches"}, stat_branches, 32'(br * 0));
    check({tag, " stat_mispredicts"}, stat_mispredicts, 32'(mis * 0));
`endif
  endtask

  initial begin
    nRST = 1'b0;
    lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; invalidate = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // lpc, uv, upc, ut, utgt, upt, uptgt, inv | exp pt, tgt, mis
    vecs.push_back(lk(32'h40, 0, 32'h0));                                           // reset state
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   1)); // allocate, same-cycle lookup pre-update
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 1, 32'h100, 1)); // ctr 2 -> 1
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 0, 32'h100, 0)); // ctr 1 -> 0
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 0, 32'h100, 0)); // ctr 0 -> 0
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 0, 32'h100, 1)); // ctr 0 -> 1 (no wrap)
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h100, 0, 0, 32'h100, 1)); // ctr 1 -> 2
    vecs.push_back(lk(32'h40, 1, 32'h100));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h200, 1, 32'h100, 0, 1, 32'h100, 1)); // wrong target, ctr 3
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h200, 1, 32'h200, 0, 1, 32'h200, 0)); // ctr 3 -> 3
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h200, 0, 1, 32'h200, 1)); // ctr 3 -> 2
    vecs.push_back(lk(32'h40, 1, 32'h200));                                          // still taken: saturated up
    vecs.push_back(mk(32'h440, 1, 32'h440, 1, 32'h300, 0, 32'h0, 0, 0, 32'h0,   1)); // alias evicts 0x40
    vecs.push_back(lk(32'h40, 0, 32'h0));
    vecs.push_back(lk(32'h440, 1, 32'h300));
    vecs.push_back(mk(32'h440, 1, 32'h840, 0, 32'h0, 0, 32'h0,   0, 1, 32'h300, 0)); // NT miss: no change
    vecs.push_back(lk(32'h440, 1, 32'h300));
    vecs.push_back(lk(32'h840, 0, 32'h0));
    vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h400, 0, 32'h0,   1, 0, 32'h0,   1)); // invalidate wins
    vecs.push_back(lk(32'h80, 0, 32'h0));
    vecs.push_back(lk(32'h440, 0, 32'h0));
    vecs.push_back(mk(32'h44, 1, 32'h44, 1, 32'h500, 1, 32'h500, 0, 0, 32'h0,   0)); // correct guess, other index
    vecs.push_back(lk(32'h44, 1, 32'h500));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      if (i == 0) check_stats("after reset", 0, 0);
    end
    check_stats("table", model_br, model_mis);

    // Reset asserted while an update is presented: update discarded,
    // mispredict still follows its inputs.
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_target = 32'h600;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0; invalidate = 1'b0; lookup_pc = 32'h44;
    @(negedge CLK);
    check("reset mispredict", {31'b0, mispredict}, 32'd1);
    @(posedge CLK);
    #1;
    nRST = 1'b1; upd_valid = 1'b0;
    model_br = 0; model_mis = 0;
    drive(lk(32'h48, 0, 32'h0));
    drive(lk(32'h44, 0, 32'h0));
    check_stats("after mid-update reset", 0, 0);

    // 10 resolved branches, 4 of them mispredicted (not-taken misses leave
    // the table alone).
    for (int i = 0; i < 10; i++) begin
      drive(mk(32'hC0, 1, 32'hC0, 0, 32'h0, (i < 4), 32'h0, 0, 0, 32'h0, (i < 4)));
    end
    drive(lk(32'hC0, 0, 32'h0));
    check_stats("ten updates", 10, 4);

`ifdef BRANCH_PREDICTOR_STATS_EN
    // Counter wrap at 2^32.
    @(negedge CLK);
    force dut.stat_branches_reg = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_reg;
    drive(mk(32'hC0, 1, 32'hC0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
    drive(lk(32'hC0, 0, 32'h0));
    check("wrap stat_branches", stat_branches, 32'h0);
    check("wrap stat_mispredicts", stat_mispredicts, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters, replacing the pipeline's fixed predict-not-taken policy. It sits beside `pc`: fetch looks up the current PC in the same cycle, and execute writes back each resolved branch/jump. The block also flags mispredictions so the hazard unit can flush the fetch, decode and execute latches.

## Interface
- `ENTRIES`, 16: table depth; power of two, at least 2. `IDX_W = $clog2(ENTRIES)`.
- `CTR_BITS`, 2: direction counter width, 1 to 4.
- `ADDR_W`, 32: PC width.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset; synchronous and active-low.
- `lookup_pc`  in  ADDR_W  PC currently presented to imem.
- `pred_taken`  out  1  lookup hit and counter MSB set.
- `pred_target`  out  ADDR_W  stored target on hit, else 0.
- `upd_valid`  in  1  execute resolved a control-flow instruction this cycle.
- `upd_pc`  in  ADDR_W  PC of the resolved instruction.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  ADDR_W  actual target.
- `upd_pred_taken`, `upd_pred_target`  in  1 / ADDR_W  prediction carried down the pipe with the instruction.
- `invalidate`  in  1  clears every valid bit.
- `mispredict`  out  1  combinational misprediction flag.
- `stat_branches`, `stat_mispredicts`  out  32  performance counters.

## Operation
- Index = `pc[IDX_W+1:2]`. Tag = `pc[ADDR_W-1:IDX_W+2]`.
- Each entry holds a valid bit, a tag, a target and a counter.
- Lookup is combinational. Hit = valid and tag match. `pred_taken = hit & ctr[CTR_BITS-1]`.
- `mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target))`.
- Update, applied at the edge when `upd_valid` is high:
  - On hit, the counter saturates up if taken and down if not taken. No wrap past `2^CTR_BITS-1` or 0.
  - On hit and taken, the target is overwritten.
  - On miss and taken, the entry is allocated: valid=1, tag, target, counter = `2^(CTR_BITS-1)` (weakly taken). Any previous occupant is evicted.
  - On miss and not taken, there is no change.
- `invalidate` clears all valid bits at the next edge. Counters and targets are left unchanged.

## Timing
- Reset (`nRST` low at an edge) clears all valid bits, counters and targets. Reset mid-update discards the update.
- After reset, `pred_taken=0`, `pred_target=0`, stats=0. `mispredict` is a pure function of its inputs.
- Lookup latency is 0 cycles. Update is visible to lookups from the cycle after the edge.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents.
- `invalidate` and `upd_valid` in the same cycle: `invalidate` wins and no allocation occurs. Stats still count.
- Updates are accepted every cycle; there is no back-pressure. Fetch stalls do not gate updates.

## Configuration
- Macro: `BRANCH_PREDICTOR_STATS_EN`.
- When defined:
  - `stat_branches` increments on every `upd_valid`.
  - `stat_mispredicts` increments whenever `mispredict` is high.
  - Both counters wrap modulo 2^32 and are cleared by reset only.
- When undefined, the ports remain and are tied to 0, and no counter flops are synthesised.

## Structure
- `cpu_types_pkg` gains two constants: `BP_ENTRIES_DEFAULT` and `BP_CTR_BITS_DEFAULT`.
- The parametrised entry struct stays local to the module, because its widths depend on parameters.
- Sub-module `sat_counter` (parameter WIDTH) computes the next counter value: inc/dec with saturation. It is instantiated once on the update path.
- Pipeline integration is outside this block: decode/execute latches carry `pred_taken`/`pred_target`, and `hazard_unit` consumes `mispredict`.

## Test plan
- Reset, then lookup 0x0000_0040: `pred_taken=0`, `pred_target=0`, stats=0.
- Update pc=0x40, taken, target=0x100, pred_taken=0. Then:
  - `mispredict=1` in the update cycle.
  - The next cycle's lookup 0x40 gives `pred_taken=1`, `pred_target=0x100`.
- Three not-taken updates on 0x40 after allocation: the counter goes 2→1→0→0. `pred_taken=0` after the first update, and the counter saturates at 0.
- Aliasing with ENTRIES=16: allocate 0x40, then taken update 0x440 (same index, different tag). Lookup 0x40 misses and lookup 0x440 hits.
- `invalidate` and a taken update to 0x80 in the same cycle: lookup 0x80 misses afterwards, and `stat_branches` still increments.
- With the macro defined, 10 updates of which 4 mispredict: `stat_branches=10`, `stat_mispredicts=4`. Preload the counter to 0xFFFF_FFFF and one more update wraps it to 0.
